// File: rtl/quad_enc_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
// Holds the FSM state encoding, direction constants and the position-to-A/B phase map.
package quad_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_JOG  = 2'd2
    } state_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Two low position bits select one of four quadrature phases, Gray ordered.
    function automatic logic [1:0] phase2ab(input logic [1:0] phase);
        case (phase)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_gen_step_prescaler.sv
// Step-rate prescaler: emits one tick every div+1 enabled cycles.
// The divider value is captured on load so the caller's div input may change mid-move.
module step_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            div_reg <= div;
            cnt_reg <= div;
        end else if (enable) begin
            if (cnt_reg == '0) begin
                cnt_reg <= div_reg;
            end else begin
                cnt_reg <= cnt_reg - DIV_W'(1);
            end
        end
    end

    assign tick = enable && (cnt_reg == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: counted moves, continuous jog and abort, producing A/B/Z
// and a position counter modulo CPR. One count at most per cycle, so A/B stay Gray coded.
module quad_encoder_gen
    import quad_enc_pkg::*;
#(
    parameter int CPR   = 4096,
    parameter int POS_W = 12,
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] div,
    input  logic             jog_cw,
    input  logic             jog_ccw,
    input  logic             abort,
    output logic             A,
    output logic             B,
    output logic             Z,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);

    state_t           state_reg;
    logic             dir_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [POS_W-1:0] position_reg;
    logic             a_reg;
    logic             b_reg;
    logic             z_reg;
    logic             done_reg;

    logic             jog_req;
    logic             jog_stop;
    logic             load;
    logic             tick;
    logic             step_now;
    logic [POS_W-1:0] pos_next;

    assign jog_req = jog_cw ^ jog_ccw;

    // Jog ends as soon as the held direction is no longer the only one requested.
    assign jog_stop = (dir_reg == DIR_CW) ? !(jog_cw && !jog_ccw)
                                          : !(jog_ccw && !jog_cw);

    assign load = (state_reg == ST_IDLE) &&
                  (cmd_valid ? (cmd_steps != '0) : jog_req);

    assign step_now = tick && !abort &&
                      ((state_reg == ST_RUN) || ((state_reg == ST_JOG) && !jog_stop));

    always_comb begin
        pos_next = position_reg;
        if (dir_reg == DIR_CW) begin
            pos_next = (position_reg == POS_MAX) ? '0 : position_reg + POS_W'(1);
        end else begin
            pos_next = (position_reg == '0) ? POS_MAX : position_reg - POS_W'(1);
        end
    end

    step_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .enable (state_reg != ST_IDLE),
        .div    (div),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            dir_reg       <= DIR_CW;
            remaining_reg <= '0;
            position_reg  <= '0;
            a_reg         <= 1'b0;
            b_reg         <= 1'b0;
            z_reg         <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (step_now) begin
                position_reg   <= pos_next;
                {a_reg, b_reg} <= phase2ab(pos_next[1:0]);
                z_reg          <= (pos_next == '0);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dir_reg       <= cmd_dir;
                        remaining_reg <= cmd_steps;
                        if (cmd_steps == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end else if (jog_req) begin
                        dir_reg   <= jog_cw ? DIR_CW : DIR_CCW;
                        state_reg <= ST_JOG;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end else if (tick) begin
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        if (remaining_reg == CNT_W'(1)) begin
                            state_reg <= ST_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_JOG: begin
                    if (abort || jog_stop) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign A         = a_reg;
    assign B         = b_reg;
    assign Z         = z_reg;
    assign position  = position_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign cmd_ready = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Randomised self-checking bench for quad_encoder_gen; expectations come from step arithmetic
// (steps done = elapsed cycles / period) and the quadrature phase table.
module tb_quad_encoder_gen;

    localparam int CPR   = 64;
    localparam int POS_W = 6;
    localparam int CNT_W = 16;
    localparam int DIV_W = 8;
    localparam int OBS_W = POS_W + 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] div;
    logic             jog_cw;
    logic             jog_ccw;
    logic             abort;
    logic             A;
    logic             B;
    logic             Z;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             done;

    logic [OBS_W-1:0] obs;
    logic [OBS_W-1:0] exp_v;
    logic [1:0]       ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    int n_vec = 0;
    int n_err = 0;
    int model_pos = 0;

    quad_encoder_gen #(
        .CPR   (CPR),
        .POS_W (POS_W),
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .div       (div),
        .jog_cw    (jog_cw),
        .jog_ccw   (jog_ccw),
        .abort     (abort),
        .A         (A),
        .B         (B),
        .Z         (Z),
        .position  (position),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign obs = {position, A, B, Z, busy, cmd_ready, done};

    function automatic int wrap(input int p);
        return ((p % CPR) + CPR) % CPR;
    endfunction

    // Expected {position, A, B, Z, busy, cmd_ready, done} for a given shaft position.
    function automatic logic [OBS_W-1:0] mk_exp(input int p, input bit bsy, input bit dn);
        logic [1:0] ab;
        ab = ab_tbl[p % 4];
        return {POS_W'(p), ab, (p == 0), bsy, !bsy, dn};
    endfunction

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input bit d, input int steps, input int dv);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = CNT_W'(steps);
        div       = DIV_W'(dv);
        tick1();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; div = '0;
        jog_cw = 1'b0; jog_ccw = 1'b0; abort = 1'b0;
        tick1();
        tick1();
        exp_v = mk_exp(0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", obs, exp_v);
        end
        rst = 1'b0;
        tick1();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, exp_v);
        end
        model_pos = 0;
        $display("reset: obs=%h", obs);
    endtask

    task automatic test_cw_move();
        int start, total, k;
        start = model_pos;
        total = 8 * 4;
        issue_cmd(1'b1, 8, 3);
        for (int c = 0; c <= total + 1; c++) begin
            k = (c / 4 < 8) ? c / 4 : 8;
            exp_v = mk_exp(wrap(start + k), c < total, c == total);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL cw_move c=%0d: got %h want %h", c, obs, exp_v);
            end
            tick1();
        end
        model_pos = wrap(start + 8);
        $display("cw_move: steps=8 div=3 final pos=%0d", position);
    endtask

    task automatic test_ccw_wrap();
        int k;
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        model_pos = 0;
        issue_cmd(1'b0, 2, 0);
        for (int c = 0; c <= 3; c++) begin
            k = (c < 2) ? c : 2;
            exp_v = mk_exp(wrap(-k), c < 2, c == 2);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL ccw_wrap c=%0d: got %h want %h", c, obs, exp_v);
            end
            tick1();
        end
        model_pos = wrap(-2);
        $display("ccw_wrap: final pos=%0d AB=%b%b", position, A, B);
    endtask

    task automatic test_jog();
        int start, k, h, dv;
        bit d;
        for (int run = 0; run < 3; run++) begin
            start = model_pos;
            h  = (run == 0) ? 11 : int'($urandom_range(2, 20));
            dv = (run == 0) ? 1 : int'($urandom_range(0, 3));
            d  = (run == 0) ? 1'b1 : run[0];
            div = DIV_W'(dv);
            jog_cw  = d;
            jog_ccw = !d;
            for (int c = 0; c <= h + 2; c++) begin
                tick1();
                jog_cw  = d && (c + 1 < h);
                jog_ccw = !d && (c + 1 < h);
                k = ((c < h - 1) ? c : h - 1) / (dv + 1);
                exp_v = mk_exp(wrap(d ? start + k : start - k), c < h, 1'b0);
                n_vec++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL jog run=%0d c=%0d: got %h want %h", run, c, obs, exp_v);
                end
            end
            model_pos = wrap(d ? start + (h - 1) / (dv + 1) : start - (h - 1) / (dv + 1));
            $display("jog: dir=%0d hold=%0d div=%0d pos=%0d", d, h, dv, position);
        end
        jog_cw = 1'b1;
        jog_ccw = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick1();
            exp_v = mk_exp(model_pos, 1'b0, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL jog_both c=%0d: got %h want %h", c, obs, exp_v);
            end
        end
        jog_cw = 1'b0;
        jog_ccw = 1'b0;
        $display("jog_both: pos=%0d busy=%0d", position, busy);
    endtask

    task automatic test_abort();
        int start, k;
        start = model_pos;
        issue_cmd(1'b1, 100, 0);
        for (int c = 0; c <= 14; c++) begin
            k = (c < 9) ? c : 9;
            exp_v = mk_exp(wrap(start + k), c < 10, c == 10);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL abort c=%0d: got %h want %h", c, obs, exp_v);
            end
            abort = (c == 9);
            tick1();
        end
        abort = 1'b0;
        model_pos = wrap(start + 9);
        $display("abort: pos=%0d (start %0d)", position, start);
    endtask

    task automatic test_edge_cases();
        int start, total, k;
        // Zero-length move: done pulse only.
        start = model_pos;
        issue_cmd(1'b1, 0, int'($urandom_range(0, 5)));
        for (int c = 0; c <= 2; c++) begin
            exp_v = mk_exp(start, 1'b0, c == 0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL zero_steps c=%0d: got %h want %h", c, obs, exp_v);
            end
            tick1();
        end
        // Command held during RUN must not be taken until the move ends.
        issue_cmd(1'b1, 3, 1);
        total = 6;
        cmd_dir = 1'b0; cmd_steps = CNT_W'(5); div = DIV_W'(0);
        for (int c = 0; c <= total + 2; c++) begin
            k = (c / 2 < 3) ? c / 2 : 3;
            exp_v = mk_exp(wrap(start + k), c < total, c == total);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL cmd_in_run c=%0d: got %h want %h", c, obs, exp_v);
            end
            cmd_valid = (c + 1 <= total);
            tick1();
        end
        cmd_valid = 1'b0;
        start = wrap(start + 3);
        // Command wins over jog and abort in IDLE.
        jog_cw = 1'b1; abort = 1'b1;
        issue_cmd(1'b0, 2, 0);
        jog_cw = 1'b0; abort = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            k = (c < 2) ? c : 2;
            exp_v = mk_exp(wrap(start - k), c < 2, c == 2);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL cmd_priority c=%0d: got %h want %h", c, obs, exp_v);
            end
            tick1();
        end
        // Reset in the middle of a move.
        issue_cmd(1'b1, 20, 0);
        tick1(); tick1(); tick1();
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        exp_v = mk_exp(0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_mid_run: got %h want %h", obs, exp_v);
        end
        tick1();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_mid_run_after: got %h want %h", obs, exp_v);
        end
        model_pos = 0;
        $display("edge_cases: pos=%0d", position);
    endtask

    task automatic test_random_moves();
        int start, total, k, steps, dv;
        bit d;
        for (int t = 0; t < 12; t++) begin
            start = model_pos;
            d     = 1'($urandom_range(0, 1));
            steps = int'($urandom_range(1, 40));
            dv    = int'($urandom_range(0, 3));
            total = steps * (dv + 1);
            issue_cmd(d, steps, dv);
            div = DIV_W'($urandom_range(0, 255));
            for (int c = 0; c <= total + 1; c++) begin
                k = (c / (dv + 1) < steps) ? c / (dv + 1) : steps;
                exp_v = mk_exp(wrap(d ? start + k : start - k), c < total, c == total);
                n_vec++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL random t=%0d c=%0d: got %h want %h", t, c, obs, exp_v);
                end
                tick1();
            end
            model_pos = wrap(d ? start + steps : start - steps);
            $display("random t=%0d: dir=%0d steps=%0d div=%0d pos=%0d", t, d, steps, dv, position);
        end
    endtask

    initial begin
        test_reset();
        test_cw_move();
        test_ccw_wrap();
        test_jog();
        test_abort();
        test_edge_cases();
        test_random_moves();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
